// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    // Bit counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow-out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: diff = a - b, LSB first through one full-subtractor cell,
// with valid/ready handshakes on both the operand and the result side.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         borrow,
    output logic         overflow
);

    localparam int unsigned CntW = cnt_width(W);
    localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    diff_q, diff_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sa_q, sa_d;
    logic            sb_q, sb_d;
    logic            br_q, br_d;
    logic            borrow_q, borrow_d;
    logic            ovf_q, ovf_d;

    logic            cell_d;
    logic            cell_bout;

    full_subtractor u_cell (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sa_d    = a[W-1];
                    sb_d    = b[W-1];
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    diff_d  = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                diff_d = {cell_d, diff_q[W-1:1]};
                a_d    = {1'b0, a_q[W-1:1]};
                b_d    = {1'b0, b_q[W-1:1]};
                br_d   = cell_bout;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d  = StDone;
                    borrow_d = cell_bout;
                    // Signed overflow: operand signs differ and result sign differs from a.
                    ovf_d    = (sa_q != sb_q) && (cell_d != sa_q);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = rst_n && (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: W=8 hand-computed vectors plus a W=4 exhaustive sweep.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid8 = 1'b0, out_ready8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       in_ready8, out_valid8, borrow8, ovf8;
    logic [7:0] diff8;

    logic       in_valid4 = 1'b0, out_ready4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       in_ready4, out_valid4, borrow4, ovf4;
    logic [3:0] diff4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.W(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .diff      (diff8),
        .borrow    (borrow8),
        .overflow  (ovf8)
    );

    serial_subtractor #(.W(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .diff      (diff4),
        .borrow    (borrow4),
        .overflow  (ovf4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operand pair to the W=8 instance and return cycles from accept edge to out_valid.
    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, output int lat);
        a8 = av;
        b8 = bv;
        in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (out_valid8) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic chk_res8(input string tag, input logic [7:0] d, input logic br,
                            input logic ov);
        chk({tag, "_diff"}, 32'(diff8), 32'(d));
        chk({tag, "_borrow"}, 32'(borrow8), 32'(br));
        chk({tag, "_ovf"}, 32'(ovf8), 32'(ov));
    endtask

    initial begin
        int lat;
        int accepted;
        int produced;
        logic [3:0] ed;
        logic eb, eo, took, got;

        // Reset state.
        step();
        step();
        chk("rst_in_ready", 32'(in_ready8), 32'd0);
        chk("rst_out_valid", 32'(out_valid8), 32'd0);
        chk("rst_diff", 32'(diff8), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 32'(in_ready8), 32'd1);

        // 1: 5 - 3, latency and single-cycle out_valid.
        out_ready8 = 1'b1;
        issue8(8'h05, 8'h03, lat);
        chk("t1_latency", 32'(lat), 32'd8);
        chk_res8("t1", 8'h02, 1'b0, 1'b0);
        chk("t1_in_ready_done", 32'(in_ready8), 32'd0);
        step();
        chk("t1_valid_drop", 32'(out_valid8), 32'd0);
        chk("t1_in_ready_back", 32'(in_ready8), 32'd1);

        // 2: 0 - 1.
        issue8(8'h00, 8'h01, lat);
        chk("t2_latency", 32'(lat), 32'd8);
        chk_res8("t2", 8'hFF, 1'b1, 1'b0);
        step();

        // 3: 0x80 - 1 (signed overflow).
        issue8(8'h80, 8'h01, lat);
        chk("t3_latency", 32'(lat), 32'd8);
        chk_res8("t3", 8'h7F, 1'b0, 1'b1);
        step();

        // 4: backpressure with an ignored in_valid pulse.
        out_ready8 = 1'b0;
        issue8(8'h10, 8'h20, lat);
        chk("t4_latency", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                a8 = 8'h55;
                b8 = 8'h11;
                in_valid8 = 1'b1;
            end
            step();
            in_valid8 = 1'b0;
            chk_res8("t4_hold", 8'hF0, 1'b1, 1'b0);
            chk("t4_in_ready", 32'(in_ready8), 32'd0);
            chk("t4_out_valid", 32'(out_valid8), 32'd1);
        end
        out_ready8 = 1'b1;
        step();
        chk("t4_in_ready_after", 32'(in_ready8), 32'd1);
        chk("t4_out_valid_after", 32'(out_valid8), 32'd0);
        chk_res8("t4_kept", 8'hF0, 1'b1, 1'b0);

        // 5: reset during the third SHIFT cycle.
        a8 = 8'h33;
        b8 = 8'h11;
        in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("t5_out_valid", 32'(out_valid8), 32'd0);
        chk_res8("t5_rst", 8'h00, 1'b0, 1'b0);
        chk("t5_in_ready_low", 32'(in_ready8), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("t5_in_ready", 32'(in_ready8), 32'd1);
        issue8(8'h7F, 8'h80, lat);
        chk("t5_latency", 32'(lat), 32'd8);
        chk_res8("t5", 8'hFF, 1'b1, 1'b1);
        step();

        // 6: W=4 exhaustive with random out_ready.
        accepted = 0;
        produced = 0;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                a4 = 4'(ai);
                b4 = 4'(bi);
                in_valid4 = 1'b1;
                took = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    if (in_ready4) begin
                        took = 1'b1;
                        break;
                    end
                    step();
                end
                step();
                in_valid4 = 1'b0;
                if (took) accepted++;
                ed = 4'(ai - bi);
                eb = (ai < bi);
                eo = (a4[3] != b4[3]) && (ed[3] != a4[3]);
                got = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    if (out_valid4) begin
                        got = 1'b1;
                        break;
                    end
                    step();
                end
                chk("t6_got_output", 32'(got), 32'd1);
                chk("t6_diff", 32'(diff4), 32'(ed));
                chk("t6_borrow", 32'(borrow4), 32'(eb));
                chk("t6_ovf", 32'(ovf4), 32'(eo));
                for (int k = 0; k < 40; k++) begin
                    out_ready4 = 1'($urandom_range(0, 1));
                    step();
                    if (out_ready4) begin
                        produced++;
                        break;
                    end
                end
                out_ready4 = 1'b0;
                chk("t6_single_output", 32'(out_valid4), 32'd0);
            end
        end
        chk("t6_accepted", 32'(accepted), 32'd256);
        chk("t6_produced", 32'(produced), 32'd256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
